// File: rtl/sweep_pkg.sv
// Shared definitions for the truth-table sweeper: FSM state type and default sizing.
package sweep_pkg;

  localparam int unsigned N_IN_DEFAULT  = 3;
  localparam int unsigned HOLD_DEFAULT  = 10;
  localparam int unsigned ERR_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } sweepState_e;

endpackage

// File: rtl/sweep_hold_timer.sv
// Hold-window down-counter: reloads to HOLD-1 on load, counts down while busy,
// and flags expire on the last cycle of the window.
module sweep_hold_timer
  import sweep_pkg::*;
#(
  parameter int unsigned HOLD = HOLD_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic busy,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(HOLD);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD - 1);

  logic [CNT_W-1:0] holdCount;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      holdCount <= '0;
    end else if (load) begin
      holdCount <= RELOAD;
    end else if (busy && (holdCount != '0)) begin
      holdCount <= holdCount - 1'b1;
    end
  end

  assign expire = busy && (holdCount == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper comparing a gate under test against a golden model.
// Define SWEEP_GRAY_EN to walk the patterns in Gray order instead of binary order.
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int unsigned N_IN  = N_IN_DEFAULT,
  parameter int unsigned HOLD  = HOLD_DEFAULT,
  parameter int unsigned ERR_W = ERR_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             dut_out,
  input  logic             ref_out,
  output logic [N_IN-1:0]  stim,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [N_IN-1:0]  first_err
);

  localparam logic [N_IN-1:0]  LAST_IDX = '1;
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  sweepState_e     state, stateNext;
  logic [N_IN-1:0] sweepIdx;
  logic [N_IN-1:0] patternIdx;
  logic            inDrive;
  logic            expire;
  logic            load;
  logic            accept;
  logic            doCompare;
  logic            mismatch;
  logic            passNext;

  assign inDrive = (state == DRIVE);

  sweep_hold_timer #(
    .HOLD (HOLD)
  ) u_holdTimer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .busy   (inDrive),
    .expire (expire)
  );

`ifdef SWEEP_GRAY_EN
  assign patternIdx = sweepIdx ^ (sweepIdx >> 1);
`else
  assign patternIdx = sweepIdx;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    doCompare = 1'b0;
    load      = 1'b0;
    stim      = '0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          stateNext = DRIVE;
          accept    = 1'b1;
          load      = 1'b1;
        end
      end
      DRIVE: begin
        stim = patternIdx;
        busy = 1'b1;
        // Abort wins over a compare landing in the same cycle.
        if (abort) begin
          stateNext = IDLE;
        end else if (expire) begin
          doCompare = 1'b1;
          if (sweepIdx == LAST_IDX) begin
            stateNext = DONE;
          end else begin
            load = 1'b1;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign mismatch = (dut_out != ref_out);
  // Verdict uses the post-compare count so pass is already valid during DONE.
  assign passNext = !mismatch && (err_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sweepIdx  <= '0;
      err_cnt   <= '0;
      first_err <= '0;
      pass      <= 1'b0;
    end else if (accept) begin
      sweepIdx  <= '0;
      err_cnt   <= '0;
      first_err <= '0;
      pass      <= 1'b0;
    end else if (doCompare) begin
      if (mismatch) begin
        // The saturating count never returns to zero, so zero marks "no error yet".
        if (err_cnt == '0) begin
          first_err <= patternIdx;
        end
        if (err_cnt != ERR_MAX) begin
          err_cnt <= err_cnt + 1'b1;
        end
      end
      if (sweepIdx != LAST_IDX) begin
        sweepIdx <= sweepIdx + 1'b1;
      end else begin
        pass <= passNext;
      end
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: randomized sweeps checked against a
// behavioural model of the expected pattern windows and sweep verdicts.
module tb_truth_table_sweeper;

  localparam int N_IN   = 3;
  localparam int HOLD   = 10;
  localparam int ERR_W  = 8;
  localparam int NPAT   = 1 << N_IN;
  localparam int SWEEP  = HOLD * NPAT;
  localparam int HOLD2  = 2;
  localparam int ERR_W2 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic start2 = 1'b0;
  logic [7:0] errMask = 8'h00;

  logic [N_IN-1:0]   stim, first_err, stim2, first_err2;
  logic              busy, done, pass, busy2, done2, pass2;
  logic [ERR_W-1:0]  err_cnt;
  logic [ERR_W2-1:0] err_cnt2;
  logic              refOut, dutOut, refOut2, dutOut2;

  // Golden gate is AND3; the gate under test differs wherever errMask is set.
  assign refOut  = &stim;
  assign dutOut  = refOut ^ errMask[stim];
  assign refOut2 = &stim2;
  assign dutOut2 = ~refOut2;

  truth_table_sweeper #(.N_IN(N_IN), .HOLD(HOLD), .ERR_W(ERR_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .dut_out(dutOut), .ref_out(refOut), .stim(stim), .busy(busy),
    .done(done), .pass(pass), .err_cnt(err_cnt), .first_err(first_err)
  );

  truth_table_sweeper #(.N_IN(N_IN), .HOLD(HOLD2), .ERR_W(ERR_W2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0),
    .dut_out(dutOut2), .ref_out(refOut2), .stim(stim2), .busy(busy2),
    .done(done2), .pass(pass2), .err_cnt(err_cnt2), .first_err(first_err2)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct { int cyc; int errCnt; int firstErr; bit pass; } doneExp_t;
  typedef struct { int stimVal; int len; } window_t;
  doneExp_t doneQ[$];
  window_t  winQ[$];

  function automatic int patternOf(input int k);
`ifdef SWEEP_GRAY_EN
    return k ^ (k >> 1);
`else
    return k;
`endif
  endfunction

  // Expected verdict after the first nCmp windows have been compared.
  task automatic predict(input logic [7:0] mask, input int nCmp, input int errMax,
                         output int cnt, output int first);
    bit seen;
    cnt = 0;
    first = 0;
    seen = 0;
    for (int k = 0; k < nCmp; k++) begin
      int p;
      p = patternOf(k);
      if (mask[p]) begin
        if (!seen) first = p;
        seen = 1;
        if (cnt < errMax) cnt++;
      end
    end
  endtask

  // Window monitor: each run of a constant stim while busy must match the next expected window.
  int runStim = -1;
  int runLen = 0;
  bit prevBusy = 0;

  task automatic closeRun();
    window_t w;
    check("window expected", winQ.size() != 0, 1);
    if (winQ.size() != 0) begin
      w = winQ.pop_front();
      check("window stim", runStim, w.stimVal);
      check("window length", runLen, w.len);
    end
  endtask

  always @(negedge clk) begin
    if (prevBusy && (!busy || int'(stim) != runStim)) closeRun();
    if (busy) begin
      if (!prevBusy || int'(stim) != runStim) begin
        runStim = int'(stim);
        runLen = 1;
      end else begin
        runLen++;
      end
    end else if (rst_n) begin
      check("stim idle", stim, 0);
    end
    prevBusy = busy;
  end

  // Done monitor: every done pulse consumes one predicted verdict.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      doneExp_t e;
      check("done expected", doneQ.size() != 0, 1);
      if (doneQ.size() != 0) begin
        e = doneQ.pop_front();
        check("done cycle", cycle, e.cyc);
        check("done err_cnt", err_cnt, e.errCnt);
        check("done first_err", first_err, e.firstErr);
        check("done pass", pass, e.pass);
        check("done busy", busy, 0);
      end
    end
  end

  // One sweep; abortAt<0 runs to completion, otherwise abort (or reset) is applied
  // in the given cycle offset. midStart pulses start while the sweep is running.
  task automatic runSweep(input logic [7:0] mask, input int abortAt, input bit useReset,
                          input int midStart, input bit abortWithStart);
    bit full;
    int nCmp, cnt, first, nWin, sc, last;
    window_t w;
    doneExp_t e;
    full = (abortAt < 0);
    nCmp = full ? NPAT : abortAt / HOLD;
    nWin = full ? NPAT : abortAt / HOLD + 1;
    predict(mask, nCmp, (1 << ERR_W) - 1, cnt, first);
    @(negedge clk);
    for (int k = 0; k < nWin; k++) begin
      w.stimVal = patternOf(k);
      w.len = (!full && k == nWin - 1) ? abortAt % HOLD + 1 : HOLD;
      winQ.push_back(w);
    end
    errMask = mask;
    rst_n = 1'b1;
    start = 1'b1;
    abort = abortWithStart;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    sc = cycle;
    if (full) begin
      e.cyc = sc + SWEEP;
      e.errCnt = cnt;
      e.firstErr = first;
      e.pass = (cnt == 0);
      doneQ.push_back(e);
    end
    last = full ? SWEEP + 1 : abortAt;
    for (int a = 0; a <= last; a++) begin
      start = (a == midStart);
      if (!full && a == abortAt) begin
        if (useReset) rst_n = 1'b0;
        else abort = 1'b1;
      end
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      rst_n = 1'b1;
    end
    check("after busy", busy, 0);
    check("after done", done, 0);
    check("after stim", stim, 0);
    if (full) begin
      check("held err_cnt", err_cnt, cnt);
      check("held first_err", first_err, first);
      check("held pass", pass, cnt == 0);
    end else begin
      check("stop err_cnt", err_cnt, useReset ? 0 : cnt);
      check("stop first_err", first_err, useReset ? 0 : first);
      check("stop pass", pass, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt, first, sc, busyCnt, abortAt, midStart;
    bit got;
    repeat (3) @(negedge clk);
    check("reset stim", stim, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset pass", pass, 0);
    check("reset err_cnt", err_cnt, 0);
    check("reset first_err", first_err, 0);
    check("reset sat err_cnt", err_cnt2, 0);

    // Start on the first edge out of reset, identical gates.
    runSweep(8'h00, -1, 0, -1, 0);
    // Single differing row at stim=5.
    runSweep(8'b0010_0000, -1, 0, 40, 0);
    // Abort at cycle offset 25, then restart from pattern 0.
    runSweep(8'b0000_0110, 25, 0, 7, 0);
    runSweep(8'h81, -1, 0, SWEEP, 1);
    // Reset in the middle of window 4 with a start ignored earlier.
    runSweep(8'hA5, 45, 1, 20, 0);

    // Saturation on the narrow-counter instance, always-wrong gate.
    predict(8'hFF, NPAT, (1 << ERR_W2) - 1, cnt, first);
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    sc = cycle;
    busyCnt = 0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (done2 === 1'b1) begin
        got = 1;
        check("sat done cycle", cycle - sc, HOLD2 * NPAT);
      end else begin
        if (busy2) busyCnt++;
        @(negedge clk);
      end
    end
    check("sat done seen", got, 1);
    check("sat busy cycles", busyCnt, HOLD2 * NPAT);
    check("sat err_cnt", err_cnt2, cnt);
    check("sat first_err", first_err2, first);
    check("sat pass", pass2, 0);

    for (int r = 0; r < 12; r++) begin
      abortAt = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, SWEEP - 1)) : -1;
      if (abortAt < 0) midStart = int'($urandom_range(1, SWEEP));
      else if (abortAt >= 2) midStart = int'($urandom_range(1, abortAt - 1));
      else midStart = -1;
      runSweep(8'($urandom), abortAt, 0, midStart, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("windows drained", winQ.size(), 0);
    check("verdicts drained", doneQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
